// File: rtl/payload_rr_scheduler.sv
// -----------------------------------------------------------------------------
// payload_rr_scheduler
//
// Round-robin scheduler that merges NUM_PORTS AXI-Stream payload requesters onto
// one shared datapath. Arbitration happens on packet boundaries only. Each
// arbitration costs one idle cycle. The granted port is then passed through
// combinationally until its tlast handshake. A small ctrlport register block
// provides per-port enables, a status word and per-port packet counters.
//
// Ports
//   axis_data_clk         sole clock, rising edge
//   axis_data_rst         synchronous active-high reset
//   s_payload_tdata       requester data, port i at [i*ITEM_W +: ITEM_W]
//   s_payload_tlast       per-port end of packet
//   s_payload_tvalid      per-port valid
//   s_payload_tready      per-port ready (only the granted port can be ready)
//   m_payload_tdata       data to the shared datapath
//   m_payload_tlast       end of packet
//   m_payload_tvalid      valid
//   m_payload_tready      datapath ready
//   m_payload_tdest       index of the granted port, held between packets
//   s_ctrlport_req_wr     register write strobe
//   s_ctrlport_req_rd     register read strobe
//   s_ctrlport_req_addr   byte address
//   s_ctrlport_req_data   write data
//   s_ctrlport_resp_ack   one-cycle response strobe, one cycle after request
//   s_ctrlport_resp_data  read data (0 on write acks)
//
// Register map (byte addresses)
//   0x00        ENABLE  [NUM_PORTS-1:0] RW, unused bits read 0
//   0x04        STATUS  RO {bit 8 busy, bits 2:0 grant}
//   0x08+4*i    PKT_CNT[i] RO, any write clears it
// -----------------------------------------------------------------------------
module payload_rr_scheduler #(
   parameter int NUM_PORTS = 2,
   parameter int ITEM_W    = 32
) (
   input  logic                        axis_data_clk,
   input  logic                        axis_data_rst,
   input  logic [NUM_PORTS*ITEM_W-1:0] s_payload_tdata,
   input  logic [NUM_PORTS-1:0]        s_payload_tlast,
   input  logic [NUM_PORTS-1:0]        s_payload_tvalid,
   output logic [NUM_PORTS-1:0]        s_payload_tready,
   output logic [ITEM_W-1:0]           m_payload_tdata,
   output logic                        m_payload_tlast,
   output logic                        m_payload_tvalid,
   input  logic                        m_payload_tready,
   output logic [2:0]                  m_payload_tdest,
   input  logic                        s_ctrlport_req_wr,
   input  logic                        s_ctrlport_req_rd,
   input  logic [19:0]                 s_ctrlport_req_addr,
   input  logic [31:0]                 s_ctrlport_req_data,
   output logic                        s_ctrlport_resp_ack,
   output logic [31:0]                 s_ctrlport_resp_data
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_PASS = 1'b1;

   localparam logic [19:0] ADDR_ENABLE   = 20'h00;
   localparam logic [19:0] ADDR_STATUS   = 20'h04;
   localparam logic [19:0] ADDR_CNT_BASE = 20'h08;

   logic [0:0]           state;
   logic [2:0]           grant;
   logic [2:0]           last_grant;
   logic [2:0]           tdest_r;
   logic [NUM_PORTS-1:0] enable;
   logic [31:0]          pkt_cnt [NUM_PORTS];

   // ---------------------------------------------------------------------------
   // Arbitration: first requesting, enabled port after last_grant, with wrap.
   // ---------------------------------------------------------------------------
   logic [NUM_PORTS-1:0] arb_req;
   logic                 arb_found;
   logic [2:0]           arb_port;

   always_comb begin
      arb_req   = s_payload_tvalid & enable;
      arb_found = 1'b0;
      arb_port  = 3'd0;
      for (int off = 1; off <= NUM_PORTS; off++) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (!arb_found && arb_req[p] &&
                (p == ((int'(last_grant) + off) % NUM_PORTS))) begin
               arb_found = 1'b1;
               arb_port  = 3'(p);
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Pass-through of the granted port. Reset gates the path immediately so a
   // partial packet is dropped in the same cycle reset is seen.
   // ---------------------------------------------------------------------------
   logic              pass;
   logic [ITEM_W-1:0] sel_data;
   logic              sel_last;
   logic              sel_valid;
   logic              m_hs;
   logic              eop;

   assign pass = (state == ST_PASS) && !axis_data_rst;

   always_comb begin
      sel_data  = '0;
      sel_last  = 1'b0;
      sel_valid = 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (grant == 3'(p)) begin
            sel_data  = s_payload_tdata[p*ITEM_W +: ITEM_W];
            sel_last  = s_payload_tlast[p];
            sel_valid = s_payload_tvalid[p];
         end
      end
   end

   always_comb begin
      s_payload_tready = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (pass && (grant == 3'(p))) begin
            s_payload_tready[p] = m_payload_tready;
         end
      end
   end

   assign m_payload_tdata  = sel_data;
   assign m_payload_tlast  = sel_last;
   assign m_payload_tvalid = pass & sel_valid;
   assign m_payload_tdest  = tdest_r;

   assign m_hs = m_payload_tvalid & m_payload_tready;
   assign eop  = m_hs & sel_last;

   // ---------------------------------------------------------------------------
   // Scheduler FSM. Grant and tdest only change on the IDLE->PASS transition,
   // so they stay frozen for the whole packet and hold while idle.
   // ---------------------------------------------------------------------------
   always_ff @(posedge axis_data_clk) begin
      if (axis_data_rst) begin
         state      <= ST_IDLE;
         grant      <= 3'd0;
         last_grant <= 3'(NUM_PORTS - 1);
         tdest_r    <= 3'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (arb_found) begin
                  grant   <= arb_port;
                  tdest_r <= arb_port;
                  state   <= ST_PASS;
               end
            end
            ST_PASS: begin
               if (eop) begin
                  last_grant <= grant;
                  state      <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Register decode
   // ---------------------------------------------------------------------------
   logic                 req_any;
   logic                 enable_hit;
   logic                 status_hit;
   logic [NUM_PORTS-1:0] cnt_hit;
   logic                 map_hit;
   logic [31:0]          rd_data;
   logic                 unused_wdata;

   assign req_any    = s_ctrlport_req_wr | s_ctrlport_req_rd;
   assign enable_hit = (s_ctrlport_req_addr == ADDR_ENABLE);
   assign status_hit = (s_ctrlport_req_addr == ADDR_STATUS);
   assign map_hit    = enable_hit | status_hit | (|cnt_hit);

   // Write data above the enable field has no destination.
   assign unused_wdata = ^s_ctrlport_req_data[31:NUM_PORTS];

   always_comb begin
      cnt_hit = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         cnt_hit[p] = (s_ctrlport_req_addr == (ADDR_CNT_BASE + 20'(4 * p)));
      end
   end

   always_comb begin
      rd_data = '0;
      if (enable_hit) begin
         rd_data[NUM_PORTS-1:0] = enable;
      end else if (status_hit) begin
         rd_data = {23'd0, (state == ST_PASS), 5'd0, grant};
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (cnt_hit[p]) begin
               rd_data = pkt_cnt[p];
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Register state and response
   // ---------------------------------------------------------------------------
   always_ff @(posedge axis_data_clk) begin
      if (axis_data_rst) begin
         enable <= '1;
      end else if (s_ctrlport_req_wr && enable_hit) begin
         enable <= s_ctrlport_req_data[NUM_PORTS-1:0];
      end
   end

   // A clearing write takes priority over a same-cycle end-of-packet count.
   always_ff @(posedge axis_data_clk) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (axis_data_rst) begin
            pkt_cnt[p] <= 32'd0;
         end else if (s_ctrlport_req_wr && cnt_hit[p]) begin
            pkt_cnt[p] <= 32'd0;
         end else if (eop && (grant == 3'(p))) begin
            pkt_cnt[p] <= pkt_cnt[p] + 32'd1;
         end
      end
   end

   always_ff @(posedge axis_data_clk) begin
      if (axis_data_rst) begin
         s_ctrlport_resp_ack  <= 1'b0;
         s_ctrlport_resp_data <= 32'd0;
      end else begin
         s_ctrlport_resp_ack  <= req_any && map_hit;
         s_ctrlport_resp_data <= (req_any && map_hit && !s_ctrlport_req_wr) ? rd_data : 32'd0;
      end
   end

endmodule

// File: tb/tb_payload_rr_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for payload_rr_scheduler (NUM_PORTS=2, ITEM_W=32).
// Per-port source queues hold the packets still to be sent. A cycle-level
// reference model predicts round-robin grants, pass-through data, readies,
// packet counters and ctrlport responses.
// -----------------------------------------------------------------------------
module tb_payload_rr_scheduler;
   localparam int NP = 2;
   localparam int IW = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic [NP*IW-1:0] s_tdata;
   logic [NP-1:0]    s_tlast;
   logic [NP-1:0]    s_tvalid;
   logic [NP-1:0]    s_tready;
   logic [IW-1:0]    m_tdata;
   logic             m_tlast;
   logic             m_tvalid;
   logic             m_tready;
   logic [2:0]       m_tdest;
   logic             req_wr;
   logic             req_rd;
   logic [19:0]      req_addr;
   logic [31:0]      req_data;
   logic             resp_ack;
   logic [31:0]      resp_data;

   always #5 clk = ~clk;

   payload_rr_scheduler #(.NUM_PORTS(NP), .ITEM_W(IW)) dut (
      .axis_data_clk       (clk),
      .axis_data_rst       (rst),
      .s_payload_tdata     (s_tdata),
      .s_payload_tlast     (s_tlast),
      .s_payload_tvalid    (s_tvalid),
      .s_payload_tready    (s_tready),
      .m_payload_tdata     (m_tdata),
      .m_payload_tlast     (m_tlast),
      .m_payload_tvalid    (m_tvalid),
      .m_payload_tready    (m_tready),
      .m_payload_tdest     (m_tdest),
      .s_ctrlport_req_wr   (req_wr),
      .s_ctrlport_req_rd   (req_rd),
      .s_ctrlport_req_addr (req_addr),
      .s_ctrlport_req_data (req_data),
      .s_ctrlport_resp_ack (resp_ack),
      .s_ctrlport_resp_data(resp_data)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // Source queues: {tlast, tdata} items still to be delivered per port.
   logic [IW:0] src_q [NP][$];

   // Reference model state
   int          model_last = NP - 1;
   logic [NP-1:0] en_cur   = '1;
   logic [NP-1:0] en_prev  = '1;
   logic [NP-1:0] pend_prev = '0;
   int          cur_dest   = 0;
   bit          in_pkt     = 1'b0;
   logic [31:0] exp_cnt [NP];
   bit          exp_ack    = 1'b0;
   logic [31:0] exp_rdata  = '0;
   int          items_out  = 0;
   int          start_log[$];
   bit          ready_rand = 1'b0;
   bit          last_mv    = 1'b0;
   bit          last_ack   = 1'b0;
   logic [31:0] last_rdata = '0;

   function automatic int rr_pick(input int last, input logic [NP-1:0] pend,
                                  input logic [NP-1:0] en);
      for (int off = 1; off <= NP; off++) begin
         int p;
         p = (last + off) % NP;
         if (pend[p] && en[p]) return p;
      end
      return -1;
   endfunction

   task automatic drive_sources();
      for (int p = 0; p < NP; p++) begin
         if (src_q[p].size() != 0) begin
            s_tvalid[p] = 1'b1;
            {s_tlast[p], s_tdata[p*IW +: IW]} = src_q[p][0];
         end else begin
            s_tvalid[p] = 1'b0;
            s_tlast[p]  = 1'b0;
            s_tdata[p*IW +: IW] = '0;
         end
      end
   endtask

   task automatic load_pkt(input int p, input int len);
      for (int i = 0; i < len; i++) begin
         logic [31:0] d;
         d = $urandom;
         src_q[p].push_back({(i == len - 1), d});
      end
      drive_sources();
   endtask

   function automatic bit all_empty();
      for (int p = 0; p < NP; p++) if (src_q[p].size() != 0) return 1'b0;
      return 1'b1;
   endfunction

   // One clock cycle: sample and check at negedge, update model after posedge.
   task automatic cycle();
      logic [NP-1:0] pend_now;
      logic [NP-1:0] exp_rdy;
      bit            mv;
      bit            pop_last;
      int            pop_p;
      int            e;
      int            idx;
      bit            wr_s;
      bit            rd_s;
      bit            hit;
      logic [19:0]   a_s;
      logic [31:0]   d_s;
      logic [31:0]   rd_pred;

      @(negedge clk);
      mv       = m_tvalid;
      last_mv  = mv;
      pop_p    = -1;
      pop_last = 1'b0;
      for (int p = 0; p < NP; p++) pend_now[p] = (src_q[p].size() != 0);

      n_cmp++;
      if (resp_ack !== exp_ack) begin
         n_fail++;
         $display("FAIL ctrl_ack: got %0b expected %0b", resp_ack, exp_ack);
      end
      if (exp_ack && resp_ack === 1'b1) begin
         n_cmp++;
         if (resp_data !== exp_rdata) begin
            n_fail++;
            $display("FAIL ctrl_data: got %08h expected %08h", resp_data, exp_rdata);
         end
      end
      last_ack = resp_ack;
      if (resp_ack === 1'b1) last_rdata = resp_data;

      if (rst) begin
         n_cmp++;
         if (m_tvalid !== 1'b0 || s_tready !== '0) begin
            n_fail++;
            $display("FAIL rst_outputs: got tvalid=%0b tready=%0b expected 0/0", m_tvalid, s_tready);
         end
      end else begin
         if (mv && !in_pkt) begin
            e = rr_pick(model_last, pend_prev, en_prev);
            n_cmp++;
            if (int'(m_tdest) != e) begin
               n_fail++;
               $display("FAIL rr_grant: got %0d expected %0d", m_tdest, e);
            end
            in_pkt   = 1'b1;
            cur_dest = int'(m_tdest);
            start_log.push_back(cur_dest);
         end
         n_cmp++;
         if (m_tdest !== 3'(cur_dest)) begin
            n_fail++;
            $display("FAIL tdest_stable: got %0d expected %0d", m_tdest, cur_dest);
         end
         if (mv) begin
            n_cmp++;
            if (src_q[cur_dest].size() == 0) begin
               n_fail++;
               $display("FAIL item: got extra item %08h expected none", m_tdata);
            end else if ({m_tlast, m_tdata} !== src_q[cur_dest][0]) begin
               n_fail++;
               $display("FAIL item: got %09h expected %09h", {m_tlast, m_tdata}, src_q[cur_dest][0]);
            end else if (m_tready) begin
               pop_p    = cur_dest;
               pop_last = m_tlast;
            end
         end
         for (int p = 0; p < NP; p++) exp_rdy[p] = (mv && p == cur_dest) ? m_tready : 1'b0;
         n_cmp++;
         if (s_tready !== exp_rdy) begin
            n_fail++;
            $display("FAIL s_tready: got %b expected %b", s_tready, exp_rdy);
         end
      end

      wr_s = req_wr;
      rd_s = req_rd;
      a_s  = req_addr;
      d_s  = req_data;
      hit  = (a_s == 20'h0) || (a_s == 20'h4) ||
             (a_s >= 20'h8 && int'(a_s) < 8 + 4 * NP && a_s[1:0] == 2'b00);
      idx  = (int'(a_s) - 8) / 4;
      rd_pred = '0;
      if (a_s == 20'h0)      rd_pred = 32'(en_cur);
      else if (a_s == 20'h4) rd_pred = {23'd0, mv, 5'd0, 3'(cur_dest)};
      else if (hit)          rd_pred = exp_cnt[idx];

      @(posedge clk);
      #1;
      if (rst) begin
         exp_ack    = 1'b0;
         exp_rdata  = '0;
         model_last = NP - 1;
         en_cur     = '1;
         en_prev    = '1;
         pend_prev  = pend_now;
         cur_dest   = 0;
         in_pkt     = 1'b0;
         for (int p = 0; p < NP; p++) exp_cnt[p] = '0;
      end else begin
         exp_ack   = (wr_s || rd_s) && hit;
         exp_rdata = wr_s ? 32'd0 : rd_pred;
         if (pop_p >= 0) begin
            void'(src_q[pop_p].pop_front());
            items_out++;
            if (pop_last) begin
               in_pkt     = 1'b0;
               model_last = pop_p;
               exp_cnt[pop_p] = exp_cnt[pop_p] + 32'd1;
            end
         end
         en_prev   = en_cur;
         pend_prev = pend_now;
         if (wr_s && a_s == 20'h0) en_cur = d_s[NP-1:0];
         if (wr_s && hit && a_s >= 20'h8) exp_cnt[idx] = '0;
      end
      req_wr   = 1'b0;
      req_rd   = 1'b0;
      m_tready = ready_rand ? 1'($urandom % 2) : 1'b1;
      drive_sources();
   endtask

   task automatic reg_read(input logic [19:0] a, output bit ack, output logic [31:0] d);
      req_rd   = 1'b1;
      req_addr = a;
      cycle();
      cycle();
      ack = last_ack;
      d   = ack ? last_rdata : 32'hDEAD_BEEF;
   endtask

   task automatic reg_write(input logic [19:0] a, input logic [31:0] d);
      req_wr   = 1'b1;
      req_addr = a;
      req_data = d;
      cycle();
      cycle();
   endtask

   task automatic drain(input int bound);
      int n;
      n = 0;
      while ((!all_empty() || in_pkt) && n < bound) begin
         cycle();
         n++;
      end
      n_cmp++;
      if (n >= bound) begin
         n_fail++;
         $display("FAIL drain_timeout: got %0d cycles expected < %0d", n, bound);
      end
   endtask

   task automatic test_reset();
      bit          ack;
      logic [31:0] d;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      cycle();
      cycle();
      rst = 1'b0;
      n_cmp++;
      if (resp_data !== 32'd0 || m_tdest !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_regs: got data=%08h tdest=%0d expected 0/0", resp_data, m_tdest);
      end
      reg_read(20'h00, ack, d);
      n_cmp++;
      if (!ack || d !== 32'h3) begin
         n_fail++;
         $display("FAIL reset_enable: got ack=%0b data=%08h expected 1/00000003", ack, d);
      end
      reg_read(20'h04, ack, d);
      n_cmp++;
      if (!ack || d !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_status: got ack=%0b data=%08h expected 1/00000000", ack, d);
      end
      reg_read(20'h08, ack, d);
      n_cmp++;
      if (!ack || d !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_cnt0: got ack=%0b data=%08h expected 1/00000000", ack, d);
      end
   endtask

   task automatic test_round_robin();
      int          n;
      bit          ack;
      logic [31:0] d;
      bit          seq_ok;
      start_log.delete();
      for (int k = 0; k < 5; k++) begin
         load_pkt(0, 4);
         load_pkt(1, 4);
      end
      n = 0;
      while (items_out < 40 && n < 200) begin
         cycle();
         n++;
      end
      n_cmp++;
      if (n != 50) begin
         n_fail++;
         $display("FAIL rr_cycles: got %0d expected 50", n);
      end
      seq_ok = (start_log.size() == 10);
      for (int k = 0; k < start_log.size(); k++) if (start_log[k] != k % 2) seq_ok = 1'b0;
      n_cmp++;
      if (!seq_ok) begin
         n_fail++;
         $display("FAIL rr_sequence: got %p expected alternating 0,1 x10", start_log);
      end
      reg_read(20'h08, ack, d);
      n_cmp++;
      if (!ack || d !== 32'd5) begin
         n_fail++;
         $display("FAIL rr_cnt0: got %08h expected 00000005", d);
      end
      reg_read(20'h0C, ack, d);
      n_cmp++;
      if (!ack || d !== 32'd5) begin
         n_fail++;
         $display("FAIL rr_cnt1: got %08h expected 00000005", d);
      end
   endtask

   task automatic test_enable_midpacket();
      bit          ack;
      logic [31:0] d;
      int          n;
      int          zeros;
      start_log.delete();
      for (int k = 0; k < 3; k++) begin
         load_pkt(0, 4);
         load_pkt(1, 4);
      end
      cycle();
      cycle();
      n_cmp++;
      if (!in_pkt || cur_dest != 0) begin
         n_fail++;
         $display("FAIL en_setup: got in_pkt=%0b dest=%0d expected 1/0", in_pkt, cur_dest);
      end
      reg_write(20'h00, 32'h2);
      n = 0;
      while ((src_q[1].size() != 0 || in_pkt) && n < 200) begin
         cycle();
         n++;
      end
      repeat (5) cycle();
      n_cmp++;
      if (src_q[0].size() != 8) begin
         n_fail++;
         $display("FAIL en_port0_left: got %0d expected 8", src_q[0].size());
      end
      zeros = 0;
      foreach (start_log[k]) if (start_log[k] == 0) zeros++;
      n_cmp++;
      if (zeros != 1) begin
         n_fail++;
         $display("FAIL en_port0_pkts: got %0d expected 1", zeros);
      end
      reg_write(20'h00, 32'hFFFF_FFFF);
      reg_read(20'h00, ack, d);
      n_cmp++;
      if (!ack || d !== 32'h3) begin
         n_fail++;
         $display("FAIL en_unused_bits: got %08h expected 00000003", d);
      end
      drain(300);
   endtask

   task automatic test_backpressure();
      int total;
      int base;
      total = 0;
      base  = items_out;
      for (int p = 0; p < NP; p++) begin
         int np;
         np = $urandom_range(2, 4);
         for (int k = 0; k < np; k++) begin
            int len;
            len = $urandom_range(1, 6);
            load_pkt(p, len);
            total += len;
         end
      end
      ready_rand = 1'b1;
      m_tready   = 1'($urandom % 2);
      drain(2000);
      ready_rand = 1'b0;
      m_tready   = 1'b1;
      n_cmp++;
      if (items_out - base != total) begin
         n_fail++;
         $display("FAIL bp_items: got %0d expected %0d", items_out - base, total);
      end
   endtask

   task automatic test_counter_clear();
      bit          ack;
      logic [31:0] d;
      int          n;
      reg_write(20'h08, 32'h0);
      for (int k = 0; k < 3; k++) load_pkt(0, 2);
      drain(100);
      reg_read(20'h08, ack, d);
      n_cmp++;
      if (!ack || d !== 32'd3) begin
         n_fail++;
         $display("FAIL cnt_three: got ack=%0b data=%08h expected 1/00000003", ack, d);
      end
      load_pkt(0, 4);
      n = 0;
      while (!(in_pkt && src_q[0].size() == 1) && n < 20) begin
         cycle();
         n++;
      end
      req_wr   = 1'b1;
      req_addr = 20'h08;
      req_data = 32'h1234;
      cycle();
      cycle();
      reg_read(20'h08, ack, d);
      n_cmp++;
      if (!ack || d !== 32'd0) begin
         n_fail++;
         $display("FAIL cnt_clear_wins: got ack=%0b data=%08h expected 1/00000000", ack, d);
      end
      reg_read(20'h40, ack, d);
      n_cmp++;
      if (ack) begin
         n_fail++;
         $display("FAIL unmapped_40: got ack=1 expected 0");
      end
      reg_read(20'h10, ack, d);
      n_cmp++;
      if (ack) begin
         n_fail++;
         $display("FAIL unmapped_cnt2: got ack=1 expected 0");
      end
   endtask

   task automatic test_reset_midpacket();
      bit          ack;
      logic [31:0] d;
      int          n;
      reg_write(20'h00, 32'h2);
      start_log.delete();
      load_pkt(1, 4);
      load_pkt(0, 4);
      n = 0;
      while (!(in_pkt && src_q[1].size() == 2) && n < 20) begin
         cycle();
         n++;
      end
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      start_log.delete();
      cycle();
      n_cmp++;
      if (last_mv !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_mid_tvalid: got %0b expected 0", last_mv);
      end
      reg_read(20'h00, ack, d);
      n_cmp++;
      if (!ack || d !== 32'h3) begin
         n_fail++;
         $display("FAIL rst_mid_enable: got %08h expected 00000003", d);
      end
      drain(100);
      n_cmp++;
      if (start_log.size() == 0 || start_log[0] != 0) begin
         n_fail++;
         $display("FAIL rst_mid_first_grant: got %p expected first 0", start_log);
      end
   endtask

   initial begin
      rst      = 1'b1;
      s_tdata  = '0;
      s_tlast  = '0;
      s_tvalid = '0;
      m_tready = 1'b1;
      req_wr   = 1'b0;
      req_rd   = 1'b0;
      req_addr = '0;
      req_data = '0;
      for (int p = 0; p < NP; p++) exp_cnt[p] = '0;

      test_reset();
      test_round_robin();
      test_enable_midpacket();
      test_backpressure();
      test_counter_clear();
      test_reset_midpacket();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
